hazard_scoreboard: RTL and testbench

- Producer-side companion to the EX-stage forwarding logic. Tracks in-flight destination registers and how many cycles remain until each result becomes forwardable.
- Raises a stall at the ID/EX boundary when forwarding alone cannot resolve a dependency. Cases covered: load-use, multi-cycle (long) ops, WAW behind a long op, and the single long unit being busy.
- Sits in the ID stage. Its `issue` output gates the ID/EX register write; its stall freezes PC and IF/ID.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : ID-stage instruction attributes presented to the hazard
//               scoreboard, plus the stall/issue decisions and occupancy
//               status returned by it.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
   parameter int NREG = 32
);
   logic            id_valid;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic            id_uses_rs1;
   logic            id_uses_rs2;
   logic [4:0]      id_rd;
   logic            id_reg_write;
   logic            id_is_load;
   logic            id_is_long;
   logic            flush;
   logic            stall;
   logic            issue;
   logic            long_busy;
   logic [NREG-1:0] busy_mask;

   // ID stage / pipeline control side
   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_reg_write, id_is_load, id_is_long, flush,
      input  stall, issue, long_busy, busy_mask
   );

   // Scoreboard side
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             id_rd, id_reg_write, id_is_load, id_is_long, flush,
      output stall, issue, long_busy, busy_mask
   );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks cycles until each in-flight destination register is
//               forwardable and raises a stall at ID/EX for load-use,
//               long-op RAW, WAW behind a long op and long-unit busy.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int LONG_LAT = 4,
   parameter int CW       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   hazard_scoreboard_if.slave sb
);

   localparam logic [CW-1:0] c_long_lat = CW'(LONG_LAT);
   localparam logic [CW-1:0] c_one      = CW'(1);

   // Counter view indexed by the 5-bit register fields; x0 and any index
   // beyond NREG read as permanently zero.
   logic [CW-1:0] w_cnt [0:31];
   logic [CW-1:0] r_long_cnt;
   logic [CW-1:0] w_new_cnt;
   logic          w_raw1;
   logic          w_raw2;
   logic          w_waw;
   logic          w_str;
   logic          w_stall;
   logic          w_issue;
   logic          w_wr_en;
   logic [NREG-1:0] w_busy;

   // Latency this instruction would load into its destination counter
   always_comb begin
      w_new_cnt = '0;
      if (sb.id_is_long)
         w_new_cnt = c_long_lat;
      else if (sb.id_is_load)
         w_new_cnt = c_one;
   end

   assign w_raw1  = sb.id_uses_rs1 & (sb.id_rs1 != 5'd0) & (w_cnt[sb.id_rs1] != '0);
   assign w_raw2  = sb.id_uses_rs2 & (sb.id_rs2 != 5'd0) & (w_cnt[sb.id_rs2] != '0);
   assign w_waw   = sb.id_reg_write & (sb.id_rd != 5'd0) & (w_cnt[sb.id_rd] > w_new_cnt);
   // A new long op may follow once the previous one is in its final cycle
   assign w_str   = sb.id_is_long & (r_long_cnt > c_one);
   assign w_stall = sb.id_valid & (w_raw1 | w_raw2 | w_waw | w_str);
   // flush kills the ID instruction but does not mask the stall itself
   assign w_issue = sb.id_valid & ~w_stall & ~sb.flush;
   assign w_wr_en = w_issue & sb.id_reg_write & (sb.id_rd != 5'd0);

   assign sb.stall = w_stall;
   assign sb.issue = w_issue;

   for (genvar r = 0; r < 32; r++) begin : g_cnt
      if ((r >= 1) && (r < NREG)) begin : g_live
         localparam logic [4:0] c_idx = 5'(r);
         logic [CW-1:0] r_cnt;

         // Issue write takes precedence over the per-cycle countdown
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_cnt <= '0;
            else if (w_wr_en && (sb.id_rd == c_idx))
               r_cnt <= w_new_cnt;
            else if (r_cnt != '0)
               r_cnt <= r_cnt - c_one;
         end

         assign w_cnt[r] = r_cnt;
      end else begin : g_zero
         assign w_cnt[r] = '0;
      end
   end

   // Long unit occupancy: reload on long issue, otherwise count down
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_long_cnt <= '0;
      else if (w_issue && sb.id_is_long)
         r_long_cnt <= c_long_lat;
      else if (r_long_cnt != '0)
         r_long_cnt <= r_long_cnt - c_one;
   end

   // Occupancy status derived only from registered counters
   always_comb begin
      w_busy = '0;
      for (int r = 0; r < NREG; r++)
         w_busy[r] = (w_cnt[r] != '0);
   end

   assign sb.busy_mask = w_busy;
   assign sb.long_busy = (r_long_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. The reference
//               model keeps an absolute "ready cycle" per register and for
//               the long unit; remaining latency is ready - now.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

   localparam int NREG     = 32;
   localparam int LONG_LAT = 4;
   localparam int CW       = 4;

   logic clk;
   logic rst_n;

   hazard_scoreboard_if #(.NREG(NREG)) bus ();

   hazard_scoreboard #(
      .NREG    (NREG),
      .LONG_LAT(LONG_LAT),
      .CW      (CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .sb   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int ready [32];
   int long_ready;
   int now;

   logic obs_issue;
   logic obs_stall;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rem(input int r);
      if (r == 0) return 0;
      return (ready[r] > now) ? ready[r] - now : 0;
   endfunction

   function automatic int lat_of();
      if (bus.id_is_long) return LONG_LAT;
      if (bus.id_is_load) return 1;
      return 0;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) ready[r] = 0;
      long_ready = 0;
   endtask

   // One clock cycle: compare at the falling edge, advance model at the rising edge
   task automatic cycle();
      logic raw1, raw2, waw, str, e_stall, e_issue, e_lb;
      logic [NREG-1:0] e_mask;
      int lat;
      @(negedge clk);
      lat  = lat_of();
      raw1 = bus.id_uses_rs1 && (bus.id_rs1 != 0) && (rem(int'(bus.id_rs1)) > 0);
      raw2 = bus.id_uses_rs2 && (bus.id_rs2 != 0) && (rem(int'(bus.id_rs2)) > 0);
      waw  = bus.id_reg_write && (bus.id_rd != 0) && (rem(int'(bus.id_rd)) > lat);
      str  = bus.id_is_long && ((long_ready - now) > 1);
      e_stall = bus.id_valid && (raw1 || raw2 || waw || str);
      e_issue = bus.id_valid && !e_stall && !bus.flush;
      e_lb    = (long_ready > now);
      for (int r = 0; r < NREG; r++) e_mask[r] = (rem(r) > 0);
      chk("stall", 64'(bus.stall), 64'(e_stall));
      chk("issue", 64'(bus.issue), 64'(e_issue));
      chk("long_busy", 64'(bus.long_busy), 64'(e_lb));
      chk("busy_mask", 64'(bus.busy_mask), 64'(e_mask));
      obs_issue = bus.issue;
      obs_stall = bus.stall;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else if (e_issue) begin
         if (bus.id_reg_write && bus.id_rd != 0) ready[bus.id_rd] = now + 1 + lat;
         if (bus.id_is_long) long_ready = now + 1 + LONG_LAT;
      end
      now++;
      #1;
   endtask

   task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                        input logic u2, input int rd, input logic rw, input logic ld,
                        input logic lg, input logic fl);
      bus.id_valid     = v;
      bus.id_rs1       = 5'(rs1);
      bus.id_uses_rs1  = u1;
      bus.id_rs2       = 5'(rs2);
      bus.id_uses_rs2  = u2;
      bus.id_rd        = 5'(rd);
      bus.id_reg_write = rw;
      bus.id_is_load   = ld;
      bus.id_is_long   = lg;
      bus.flush        = fl;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Hold the current instruction until it issues; bounded
   task automatic run_until_issue(output int stalls);
      stalls = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (obs_issue) break;
         stalls++;
      end
   endtask

   int st;

   initial begin
      model_clear();
      now   = 0;
      rst_n = 1'b0;
      idle();
      cycle();
      // Under reset an instruction in ID must issue with no stall
      drive(1, 5, 1, 6, 1, 5, 1, 0, 0, 0);
      cycle();
      idle();
      cycle();
      rst_n = 1'b1;

      // ALU writes x5, next reads x5: no stall
      drive(1, 1, 0, 2, 0, 5, 1, 0, 0, 0);
      cycle();
      drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);
      run_until_issue(st);
      chk("alu_use_stalls", 64'(st), 64'd0);

      // Load x7, dependent reads rs1=x7: one bubble
      drive(1, 1, 0, 0, 0, 7, 1, 1, 0, 0);
      cycle();
      drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
      run_until_issue(st);
      chk("load_use_stalls", 64'(st), 64'd1);

      // Long writes x9, dependent reads rs2=x9: LONG_LAT stalls
      drive(1, 1, 0, 0, 0, 9, 1, 0, 1, 0);
      cycle();
      drive(1, 0, 0, 9, 1, 10, 1, 0, 0, 0);
      run_until_issue(st);
      chk("long_use_stalls", 64'(st), 64'(LONG_LAT));

      // Back-to-back independent long ops: structural stall
      drive(1, 1, 0, 0, 0, 11, 1, 0, 1, 0);
      cycle();
      drive(1, 2, 0, 0, 0, 12, 1, 0, 1, 0);
      run_until_issue(st);
      chk("long_long_stalls", 64'(st), 64'(LONG_LAT - 1));
      idle();
      repeat (LONG_LAT + 1) cycle();

      // Long writes x3 then ALU writes x3: WAW until counter drains
      drive(1, 0, 0, 0, 0, 3, 1, 0, 1, 0);
      cycle();
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      run_until_issue(st);
      chk("waw_alu_stalls", 64'(st), 64'(LONG_LAT));

      // Independent long outstanding, load x3 twice back to back: no WAW
      drive(1, 0, 0, 0, 0, 12, 1, 0, 1, 0);
      cycle();
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      run_until_issue(st);
      chk("load_x3_stalls", 64'(st), 64'd0);
      run_until_issue(st);
      chk("load_x3_again_stalls", 64'(st), 64'd0);
      idle();
      repeat (LONG_LAT) cycle();

      // Writer to x0 (long) and readers of x0: never stall, x0 never busy
      drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      cycle();
      chk("x0_not_busy", 64'(bus.busy_mask[0]), 64'd0);
      drive(1, 0, 1, 0, 1, 13, 1, 0, 0, 0);
      run_until_issue(st);
      chk("x0_read_stalls", 64'(st), 64'd0);
      idle();
      repeat (LONG_LAT) cycle();

      // Load x4 then flushed dependent: stall visible, issue killed, x4 decays
      drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
      cycle();
      drive(1, 4, 1, 0, 0, 14, 1, 0, 0, 1);
      cycle();
      chk("flush_stall", 64'(obs_stall), 64'd1);
      chk("flush_issue", 64'(obs_issue), 64'd0);
      idle();
      cycle();
      chk("flush_decay", 64'(bus.busy_mask[4]), 64'd0);

      // Asynchronous reset mid-operation with cnt[4] = 1 and long busy
      drive(1, 0, 0, 0, 0, 20, 1, 0, 1, 0);
      cycle();
      drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
      cycle();
      drive(1, 4, 1, 0, 0, 15, 1, 0, 0, 0);
      chk("pre_reset_busy4", 64'(bus.busy_mask[4]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_mask", 64'(bus.busy_mask), 64'd0);
      chk("async_rst_stall", 64'(bus.stall), 64'd0);
      chk("async_rst_long", 64'(bus.long_busy), 64'd0);
      model_clear();
      cycle();
      rst_n = 1'b1;
      idle();
      cycle();

      // Randomized traffic over a small register window
      for (int i = 0; i < 400; i++) begin
         logic ld, lg;
         ld = ($urandom_range(0, 3) == 0);
         lg = ($urandom_range(0, 4) == 0);
         drive(($urandom_range(0, 7) != 0),
               int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
               int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), ld, lg,
               ($urandom_range(0, 9) == 0));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
